ct_vfmau_norm_simd_half: RTL and testbench
==========================================

Name: ct_vfmau_norm_simd_half

Overview:
Consumer side of the half-precision SIMD leading-zero anticipator in the vfmau datapath. Takes the 24-bit unnormalized adder magnitude, the anticipated shift count and the LZA all-zero flag. Applies the left normalization shift, corrects the LZA's possible one-bit under-estimate, and adjusts the exponent. Two-stage pipeline (E1 shift, E2 correct) with stall and flush, placed between the vfmau adder stage and the rounder.

Parameters:
MANT_W, 24, magnitude width; the LZA shift range is 0..MANT_W.
SHIFT_W, 5, width of shift counts.
EXP_W, 8, signed two's-complement exponent width.

Ports:
forever_cpuclk  input  1  clock
vfmau_rst  input  1  reset, synchronous, active-high
ex_norm_vld  input  1  input operand valid
ex_norm_stall  input  1  hold both stages; no capture, no advance
ex_norm_flush  input  1  kill all in-flight operations
ex_norm_mant  input  MANT_W  unnormalized magnitude
ex_norm_lza  input  SHIFT_W  anticipated leading-zero count, 0..24
ex_norm_lza_zero  input  1  LZA predicts all-zero result
ex_norm_exp  input  EXP_W  signed exponent before normalization
norm_vld  output  1  E2 result valid
norm_mant  output  MANT_W  normalized magnitude; bit[MANT_W-1]=1 unless norm_zero
norm_shift  output  SHIFT_W+1  total applied shift, 0..25
norm_exp  output  EXP_W  ex_norm_exp - norm_shift
norm_zero  output  1  result magnitude is zero
norm_exp_unf  output  1  norm_exp < 1 (signed)

Behaviour:
- Reset, sampled on the forever_cpuclk edge while vfmau_rst=1: both stage valids=0, all data registers=0. All outputs read 0 after reset.
- Priority each cycle: reset > flush > stall > normal advance.
- Flush: clears the E1 and E2 valids on the next edge, including when stall is high. Data registers may hold stale values.
- Stall with no flush: every register holds. norm_* outputs stay stable. Input is not captured, and upstream must hold it.
- E1 capture on (ex_norm_vld & ~stall & ~flush):
  - s1_vld=1.
  - If ex_norm_lza_zero=1 or ex_norm_lza>=MANT_W: s1_mant=0, s1_shift=ex_norm_lza clamped to MANT_W, s1_zero=1.
  - Otherwise: s1_mant = ex_norm_mant << ex_norm_lza (zero-fill), s1_shift=ex_norm_lza, s1_zero=0.
  - s1_exp=ex_norm_exp.
- If ex_norm_vld=0 and there is no stall: s1_vld=0.
- E2 advance when no stall: s2_vld=s1_vld. Correction:
  - If s1_zero=0 and s1_mant[MSB]=0: mant=s1_mant<<1, shift=s1_shift+1.
  - If after that correction mant is still 0, set zero=1. This covers LZA misprediction on a zero magnitude.
  - If s1_zero=0 and s1_mant[MSB]=1: pass through unchanged.
  - If s1_zero=1: mant=0, shift=s1_shift, no correction.
- E2 exponent outputs:
  - norm_exp = s1_exp - shift, computed in EXP_W bits signed with wrap.
  - norm_exp_unf=1 when the EXP_W+1-bit signed difference is < 1.
  - Both are forced to 0 when the result is zero.
- Outputs are registered E2 state. Latency is exactly 2 unstalled cycles from input to norm_vld. Throughput is 1 per cycle.
- LZA over-estimate is not corrected. The LZA guarantees error <= 1 in the under-estimate direction, and assertions flag any shifted-out 1 bit in E1.
- Back-to-back operations with a stall between them: no duplication and no loss.

Test Plan:
- Exact LZA: mant=24'h00F000, lza=8, exp=20 -> after 2 cycles norm_vld=1, norm_mant=24'hF00000, norm_shift=8, norm_exp=12, norm_exp_unf=0, norm_zero=0.
- Under-estimate: mant=24'h004000, lza=8, exp=5 -> norm_mant=24'h800000, norm_shift=9, norm_exp=-4 (8'hFC), norm_exp_unf=1.
- Zero: lza_zero=1, lza=24, mant=0 -> norm_zero=1, norm_mant=0, norm_shift=24, norm_exp=0, norm_exp_unf=0.
- Stall/flush: issue ops A, B and C back-to-back, with stall high for 3 cycles while A is in E2 -> A's outputs are held stable for 3 cycles, then B and C follow. Repeat with flush asserted while stall=1 -> norm_vld=0 the next cycle and nothing is emitted.
- Reset mid-stream: assert vfmau_rst with both stages valid -> next cycle norm_vld=0 and all outputs 0. Input presented on the cycle reset is deasserted emerges 2 cycles later.
- Random sweep of mant and exp with lza = true clz or clz-1 -> norm_mant MSB set, norm_shift=clz, exponent matches the reference model.

Source files
------------

// File: rtl/ct_vfmau_norm_simd_half.sv
// ct_vfmau_norm_simd_half: two-stage LZA-driven normalizer with one-bit under-estimate correction
module ct_vfmau_norm_simd_half #(
    parameter int MANT_W  = 24,
    parameter int SHIFT_W = 5,
    parameter int EXP_W   = 8
) (
    input  logic               forever_cpuclk,
    input  logic               vfmau_rst,
    input  logic               ex_norm_vld,
    input  logic               ex_norm_stall,
    input  logic               ex_norm_flush,
    input  logic [MANT_W-1:0]  ex_norm_mant,
    input  logic [SHIFT_W-1:0] ex_norm_lza,
    input  logic               ex_norm_lza_zero,
    input  logic [EXP_W-1:0]   ex_norm_exp,
    output logic               norm_vld,
    output logic [MANT_W-1:0]  norm_mant,
    output logic [SHIFT_W:0]   norm_shift,
    output logic [EXP_W-1:0]   norm_exp,
    output logic               norm_zero,
    output logic               norm_exp_unf
);
    logic                 cap, in_zero, fix, c_zero;
    logic [2*MANT_W-1:0]  wide;
    logic [SHIFT_W-1:0]   in_shift;
    logic                 s1_vld, s1_zero;
    logic [MANT_W-1:0]    s1_mant, c_mant;
    logic [SHIFT_W-1:0]   s1_shift;
    logic [EXP_W-1:0]     s1_exp;
    logic [SHIFT_W:0]     c_shift;
    logic [EXP_W:0]       diff;

    always_comb begin
        cap      = ex_norm_vld & ~ex_norm_stall & ~ex_norm_flush;
        in_zero  = ex_norm_lza_zero | (ex_norm_lza >= SHIFT_W'(MANT_W));
        in_shift = (ex_norm_lza >= SHIFT_W'(MANT_W)) ? SHIFT_W'(MANT_W) : ex_norm_lza;
        wide     = {{MANT_W{1'b0}}, ex_norm_mant} << ex_norm_lza;
        fix      = ~s1_zero & ~s1_mant[MANT_W-1];
        c_mant   = s1_zero ? '0 : fix ? s1_mant << 1 : s1_mant;
        c_shift  = {1'b0, s1_shift} + (SHIFT_W+1)'(fix);
        c_zero   = s1_zero | ~|c_mant;
        // one extra bit so the underflow test sees the true signed difference before wrap
        diff     = {s1_exp[EXP_W-1], s1_exp} - (EXP_W+1)'(c_shift);
    end

    always_ff @(posedge forever_cpuclk) begin
        if (vfmau_rst) begin
            s1_vld       <= 1'b0;
            s1_zero      <= 1'b0;
            s1_mant      <= '0;
            s1_shift     <= '0;
            s1_exp       <= '0;
            norm_vld     <= 1'b0;
            norm_mant    <= '0;
            norm_shift   <= '0;
            norm_exp     <= '0;
            norm_zero    <= 1'b0;
            norm_exp_unf <= 1'b0;
        end else if (ex_norm_flush) begin
            s1_vld   <= 1'b0;
            norm_vld <= 1'b0;
        end else if (!ex_norm_stall) begin
            s1_vld   <= ex_norm_vld;
            norm_vld <= s1_vld;
            if (ex_norm_vld) begin
                s1_zero  <= in_zero;
                s1_mant  <= in_zero ? '0 : wide[MANT_W-1:0];
                s1_shift <= in_shift;
                s1_exp   <= ex_norm_exp;
            end
            if (s1_vld) begin
                norm_mant    <= c_mant;
                norm_shift   <= c_shift;
                norm_zero    <= c_zero;
                norm_exp     <= c_zero ? '0 : diff[EXP_W-1:0];
                norm_exp_unf <= ~c_zero & (diff[EXP_W] | ~|diff);
            end
        end
    end

    always_ff @(posedge forever_cpuclk) begin
        if (!vfmau_rst && cap && !in_zero)
            assert (~|wide[2*MANT_W-1:MANT_W]) else $error("LZA over-estimate shifted out a set bit");
    end
endmodule

// File: tb/tb_ct_vfmau_norm_simd_half.sv
// tb_ct_vfmau_norm_simd_half: directed-vector bench for the half-precision normalizer
module tb_ct_vfmau_norm_simd_half;
    logic        clk = 1'b0;
    logic        rst, vld, stall, flush, lza_zero;
    logic [23:0] mant;
    logic [4:0]  lza;
    logic [7:0]  exp_in;
    logic        norm_vld, norm_zero, norm_exp_unf;
    logic [23:0] norm_mant;
    logic [5:0]  norm_shift;
    logic [7:0]  norm_exp;
    logic [40:0] obs;
    int          n_tests = 0, n_fail = 0;

    localparam int N = 24;
    logic [40:0] rnd_exp [N];

    ct_vfmau_norm_simd_half dut (
        .forever_cpuclk(clk), .vfmau_rst(rst), .ex_norm_vld(vld), .ex_norm_stall(stall),
        .ex_norm_flush(flush), .ex_norm_mant(mant), .ex_norm_lza(lza), .ex_norm_lza_zero(lza_zero),
        .ex_norm_exp(exp_in), .norm_vld(norm_vld), .norm_mant(norm_mant), .norm_shift(norm_shift),
        .norm_exp(norm_exp), .norm_zero(norm_zero), .norm_exp_unf(norm_exp_unf)
    );

    always #5 clk = ~clk;
    assign obs = {norm_vld, norm_mant, norm_shift, norm_exp, norm_zero, norm_exp_unf};

    function automatic logic [40:0] pk(logic v, logic [23:0] m, logic [5:0] s, logic [7:0] e, logic z, logic u);
        return {v, m, s, e, z, u};
    endfunction

    function automatic int clz(logic [23:0] m);
        int c = 24;
        for (int i = 0; i < 24; i++) if (m[i]) c = 23 - i;
        return c;
    endfunction

    task automatic check(input string tag, input logic [40:0] got, input logic [40:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    task automatic drive(input logic v, input logic [23:0] m, input logic [4:0] l, input logic z, input logic [7:0] e);
        vld = v; mant = m; lza = l; lza_zero = z; exp_in = e;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic single(input string tag, input logic [23:0] m, input logic [4:0] l, input logic z,
                          input logic [7:0] e, input logic [40:0] want);
        drive(1, m, l, z, e);
        step();
        drive(0, 0, 0, 0, 0);
        check({tag, "_lat1"}, {40'd0, norm_vld}, 41'd0);
        step();
        check(tag, obs, want);
        step();
        check({tag, "_once"}, {40'd0, norm_vld}, 41'd0);
    endtask

    initial begin
        rst = 1; stall = 0; flush = 0;
        drive(0, 0, 0, 0, 0);
        step(); step();
        check("reset", obs, 41'd0);
        rst = 0;
        step();

        single("exact",   24'h00F000, 8,  0, 8'd20,  pk(1, 24'hF00000, 8,  8'd12,  0, 0));
        single("under",   24'h004000, 8,  0, 8'd5,   pk(1, 24'h800000, 9,  8'hFC,  0, 1));
        single("zero",    24'h000000, 24, 1, 8'd33,  pk(1, 24'h000000, 24, 8'h00,  1, 0));
        single("clamp",   24'h000000, 30, 0, 8'd40,  pk(1, 24'h000000, 24, 8'h00,  1, 0));
        single("mispred", 24'h000000, 5,  0, 8'd10,  pk(1, 24'h000000, 6,  8'h00,  1, 0));
        single("wrap",    24'h400000, 0,  0, 8'h80,  pk(1, 24'h800000, 1,  8'h7F,  0, 1));
        single("exp_eq0", 24'h800000, 0,  0, 8'd0,   pk(1, 24'h800000, 0,  8'h00,  0, 1));
        single("exp_eq1", 24'h100000, 3,  0, 8'd4,   pk(1, 24'h800000, 3,  8'd1,   0, 0));

        // A, B, C back-to-back with a 3-cycle stall while A sits in E2
        drive(1, 24'h000001, 23, 0, 8'd30); step();
        drive(1, 24'h800000, 0,  0, 8'd0);  step();
        check("stall_a", obs, pk(1, 24'h800000, 23, 8'd7, 0, 0));
        drive(1, 24'h0FFFFF, 3, 0, 8'h9C); stall = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("stall_hold%0d", i), obs, pk(1, 24'h800000, 23, 8'd7, 0, 0));
        end
        stall = 0; step();
        drive(0, 0, 0, 0, 0);
        check("stall_b", obs, pk(1, 24'h800000, 0, 8'd0, 0, 1));
        step();
        check("stall_c", obs, pk(1, 24'hFFFFF0, 4, 8'h98, 0, 1));
        step();
        check("stall_end", {40'd0, norm_vld}, 41'd0);

        // flush while stalled kills both stages
        drive(1, 24'h000100, 15, 0, 8'd50); step();
        drive(1, 24'h000200, 14, 0, 8'd60); step();
        check("pre_flush", obs, pk(1, 24'h800000, 15, 8'd35, 0, 0));
        drive(0, 0, 0, 0, 0); stall = 1; flush = 1; step();
        stall = 0; flush = 0;
        check("flush0", {40'd0, norm_vld}, 41'd0);
        step();
        check("flush1", {40'd0, norm_vld}, 41'd0);
        step();
        check("flush2", {40'd0, norm_vld}, 41'd0);

        // reset with both stages full, then an op on the release cycle
        drive(1, 24'h000100, 15, 0, 8'd50); step();
        drive(1, 24'h000200, 14, 0, 8'd60); step();
        rst = 1; drive(1, 24'h000400, 13, 0, 8'd70); step();
        check("rst_mid", obs, 41'd0);
        rst = 0; drive(1, 24'h000040, 17, 0, 8'd17); step();
        drive(0, 0, 0, 0, 0);
        check("rst_lat1", {40'd0, norm_vld}, 41'd0);
        step();
        check("rst_after", obs, pk(1, 24'h800000, 17, 8'd0, 0, 1));

        // pipelined random sweep, lza = clz or clz-1
        for (int i = 0; i < N + 2; i++) begin
            if (i >= 2) check($sformatf("rnd%0d", i - 2), obs, rnd_exp[i - 2]);
            if (i < N) begin
                logic [23:0] m;
                logic [7:0]  e, ne;
                logic [23:0] em;
                int c, l, d;
                m = 24'($urandom) >> $urandom_range(0, 23);
                if (m == 0) m = 24'h1;
                e = 8'($urandom);
                c = clz(m);
                l = (c > 0 && $urandom_range(0, 1) == 1) ? c - 1 : c;
                em = m << c;
                d = int'($signed(e)) - c;
                ne = d[7:0];
                rnd_exp[i] = pk(1, em, 6'(c), ne, 0, d < 1);
                drive(1, m, 5'(l), 0, e);
            end else drive(0, 0, 0, 0, 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
